// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and special-result constants for muldiv_unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FINISH
    } state_t;

    localparam int MAX_W = 64;

    // Results are produced at MAX_W and narrowed to WIDTH by the caller.
    function automatic logic [MAX_W-1:0] div0_lo(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] ovf_lo(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [MAX_W-1:0] ovf_hi(input int w);
        return MAX_W'(0) & MAX_W'(w);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude on capture, sign fix on finish.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier on MULT/MULTU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_cpu,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_rs,
    input  logic [WIDTH-1:0] src_rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] DIV0_LO = WIDTH'(div0_lo(WIDTH));
    localparam logic [WIDTH-1:0] OVF_LO  = WIDTH'(ovf_lo(WIDTH));
    localparam logic [WIDTH-1:0] OVF_HI  = WIDTH'(ovf_hi(WIDTH));
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div0;
    logic               ovf;

    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy      = (state != ST_IDLE);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = signed_op & src_rs[WIDTH-1];
    assign sign_b    = signed_op & src_rt[WIDTH-1];

    muldiv_sign_fix #(.W(WIDTH)) u_mag_a (.val(src_rs), .neg(sign_a), .res(mag_a));
    muldiv_sign_fix #(.W(WIDTH)) u_mag_b (.val(src_rt), .neg(sign_b), .res(mag_b));

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_p (.val({rem, quo}), .neg(neg_res), .res(prod_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_q (.val(quo), .neg(neg_res), .res(quo_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_r (.val(rem), .neg(neg_rem), .res(rem_fix));

    // Multiply: {rem,quo} shifts right, quo[0] gates the add of the multiplicand.
    assign add_sum = {1'b0, rem} + (quo[0] ? {1'b0, opb} : '0);
    // Divide: restoring step, quo shifts left taking quotient bits in.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, opb};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    quo     <= mag_a;
                                    opb     <= mag_b;
                                    rem     <= '0;
                                    cnt     <= '0;
                                    is_div  <= op[1];
                                    neg_res <= sign_a ^ sign_b;
                                    neg_rem <= sign_a;
                                    div0    <= op[1] && (src_rt == '0);
                                    ovf     <= (op == OP_DIV) && (src_rs == OVF_LO)
                                               && (src_rt == '1);
                                    state   <= ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
                                    if (!op[1]) begin
                                        {rem, quo} <= fast_prod;
                                        state      <= ST_FINISH;
                                    end
`endif
                                end
                                OP_MTHI: hi_q <= src_rs;
                                OP_MTLO: lo_q <= src_rs;
                                default: ;
                            endcase
                        end
                    end
                    ST_CALC: begin
                        if (is_div) begin
                            if (!diff[WIDTH]) begin
                                rem <= diff[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b1};
                            end else begin
                                rem <= shifted[WIDTH-1:0];
                                quo <= {quo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            rem <= add_sum[WIDTH:1];
                            quo <= {add_sum[0], quo[WIDTH-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= ST_FINISH;
                    end
                    ST_FINISH: begin
                        // Divide by zero leaves the magnitude of rs in rem; re-sign it.
                        if (div0) begin
                            hi_q <= rem_fix;
                            lo_q <= DIV0_LO;
                        end else if (ovf) begin
                            hi_q <= OVF_HI;
                            lo_q <= OVF_LO;
                        end else if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk_cpu = 1'b0;
    logic         reset   = 1'b0;
    logic         start   = 1'b0;
    logic         flush   = 1'b0;
    logic [2:0]   op      = 3'd0;
    logic [W-1:0] src_rs  = '0;
    logic [W-1:0] src_rt  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    int passed = 0;
    int total  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .start(start), .op(op),
        .src_rs(src_rs), .src_rt(src_rt), .flush(flush),
        .busy(busy), .done(done), .hi_q(hi_q), .lo_q(lo_q)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    // Reference: MIPS HI/LO semantics computed with 64-bit arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_hi = '0; m_lo = a; end
                else begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
            end
            3'd3: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic run_arith(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        int cyc, busy_n, done_n, done_at, early, exp_done;
        logic [W-1:0] old_hi, old_lo;
        old_hi = hi_q; old_lo = lo_q;
        model(o, a, b);
        exp_done = (FAST && o < 3'd2) ? 2 : W + 2;
        op = o; src_rs = a; src_rt = b; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1; busy_n = 0; done_n = 0; done_at = 0; early = 0;
        repeat (40) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            if (done_at == 0 && (hi_q !== old_hi || lo_q !== old_lo)) early++;
            step();
            cyc++;
        end
        total++; if (hi_q !== m_hi) $display("FAIL %s hi: got %h want %h", nm, hi_q, m_hi); else passed++;
        total++; if (lo_q !== m_lo) $display("FAIL %s lo: got %h want %h", nm, lo_q, m_lo); else passed++;
        total++; if (done_at !== exp_done) $display("FAIL %s done cycle: got %0d want %0d", nm, done_at, exp_done); else passed++;
        total++; if (done_n !== 1) $display("FAIL %s done pulses: got %0d want 1", nm, done_n); else passed++;
        total++; if (busy_n !== exp_done - 1) $display("FAIL %s busy cycles: got %0d want %0d", nm, busy_n, exp_done - 1); else passed++;
        total++; if (early !== 0) $display("FAIL %s early hi/lo change: got %0d want 0", nm, early); else passed++;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else passed++;
        total++; if (hi_q !== '0) $display("FAIL reset hi: got %h want 0", hi_q); else passed++;
        total++; if (lo_q !== '0) $display("FAIL reset lo: got %h want 0", lo_q); else passed++;
    endtask

    task automatic test_directed();
        run_arith(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_arith(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        run_arith(3'd3, 32'd100, 32'd7, "divu_100by7");
        run_arith(3'd3, 32'h1234_5678, 32'd0, "divu_by0");
        run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_arith(3'd2, 32'hF000_0001, 32'd0, "div_neg_by0");
        run_arith(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
    endtask

    task automatic test_mt();
        logic [W-1:0] old_lo;
        int busy_n;
        old_lo = lo_q; busy_n = 0;
        op = 3'd4; src_rs = 32'hAAAA_5555; start = 1'b1;
        step();
        if (busy) busy_n++;
        total++; if (hi_q !== 32'hAAAA_5555) $display("FAIL mthi hi: got %h want aaaa5555", hi_q); else passed++;
        total++; if (lo_q !== old_lo) $display("FAIL mthi lo: got %h want %h", lo_q, old_lo); else passed++;
        op = 3'd5; src_rs = 32'h0F0F_0F0F;
        step();
        start = 1'b0;
        if (busy) busy_n++;
        total++; if (lo_q !== 32'h0F0F_0F0F) $display("FAIL mtlo lo: got %h want 0f0f0f0f", lo_q); else passed++;
        total++; if (hi_q !== 32'hAAAA_5555) $display("FAIL mtlo hi: got %h want aaaa5555", hi_q); else passed++;
        step();
        if (busy) busy_n++;
        total++; if (busy_n !== 0) $display("FAIL mt busy: got %0d want 0", busy_n); else passed++;
        total++; if (done !== 1'b0) $display("FAIL mt done: got %b want 0", done); else passed++;
        m_hi = 32'hAAAA_5555; m_lo = 32'h0F0F_0F0F;
    endtask

    task automatic test_ignored_ops();
        logic [W-1:0] old_hi, old_lo;
        for (int k = 6; k < 8; k++) begin
            old_hi = hi_q; old_lo = lo_q;
            op = 3'(k); src_rs = $urandom; src_rt = $urandom; start = 1'b1;
            step();
            start = 1'b0;
            total++; if (busy !== 1'b0) $display("FAIL op%0d busy: got %b want 0", k, busy); else passed++;
            step();
            total++; if (hi_q !== old_hi || lo_q !== old_lo || done !== 1'b0)
                $display("FAIL op%0d state: got %h/%h done %b want %h/%h done 0", k, hi_q, lo_q, done, old_hi, old_lo);
            else passed++;
        end
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] old_hi;
        int k;
        old_hi = hi_q;
        model(3'd3, 32'd1000, 32'd33);
        op = 3'd3; src_rs = 32'd1000; src_rt = 32'd33; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        op = 3'd4; src_rs = 32'hDEAD_BEEF; start = 1'b1;
        step();
        op = 3'd0; src_rs = 32'd5; src_rt = 32'd9;
        step();
        start = 1'b0;
        total++; if (hi_q !== old_hi) $display("FAIL busy_mthi hi: got %h want %h", hi_q, old_hi); else passed++;
        k = 0;
        while (!done && k < 40) begin step(); k++; end
        total++; if (done !== 1'b1) $display("FAIL busy_start timeout: got done %b want 1", done); else passed++;
        total++; if (hi_q !== m_hi || lo_q !== m_lo)
            $display("FAIL busy_start result: got %h/%h want %h/%h", hi_q, lo_q, m_hi, m_lo);
        else passed++;
        step();
        total++; if (busy !== 1'b0) $display("FAIL busy_start extra op: got busy %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int k;
        model(3'd1, 32'h0001_0000, 32'h0003_0000);
        op = 3'd1; src_rs = 32'h0001_0000; src_rt = 32'h0003_0000; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin step(); k++; end
        total++; if (done !== 1'b1) $display("FAIL b2b first timeout: got done %b want 1", done); else passed++;
        total++; if (hi_q !== m_hi || lo_q !== m_lo)
            $display("FAIL b2b first: got %h/%h want %h/%h", hi_q, lo_q, m_hi, m_lo);
        else passed++;
        model(3'd2, 32'hFFFF_FC18, 32'd13);
        op = 3'd2; src_rs = 32'hFFFF_FC18; src_rt = 32'd13; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL b2b accept: got busy %b want 1", busy); else passed++;
        k = 0;
        while (!done && k < 40) begin step(); k++; end
        total++; if (hi_q !== m_hi || lo_q !== m_lo || done !== 1'b1)
            $display("FAIL b2b second: got %h/%h done %b want %h/%h", hi_q, lo_q, done, m_hi, m_lo);
        else passed++;
    endtask

    task automatic test_flush();
        int done_n;
        op = 3'd2; src_rs = 32'd77777; src_rt = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush busy: got %b want 0", busy); else passed++;
        done_n = 0;
        repeat (40) begin if (done) done_n++; step(); end
        total++; if (done_n !== 0) $display("FAIL flush done: got %0d want 0", done_n); else passed++;
        total++; if (hi_q !== m_hi || lo_q !== m_lo)
            $display("FAIL flush hilo: got %h/%h want %h/%h", hi_q, lo_q, m_hi, m_lo);
        else passed++;
        op = 3'd4; src_rs = 32'h1111_2222; start = 1'b1; flush = 1'b1;
        step();
        op = 3'd0; src_rs = 32'd3; src_rt = 32'd3;
        step();
        start = 1'b0; flush = 1'b0;
        step();
        total++; if (busy !== 1'b0 || hi_q !== m_hi || lo_q !== m_lo)
            $display("FAIL flush_start: got busy %b %h/%h want 0 %h/%h", busy, hi_q, lo_q, m_hi, m_lo);
        else passed++;
    endtask

    task automatic test_reset_mid();
        op = 3'd3; src_rs = 32'hFFFF_0000; src_rt = 32'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || hi_q !== '0 || lo_q !== '0)
            $display("FAIL reset_mid: got busy %b done %b %h/%h want all zero", busy, done, hi_q, lo_q);
        else passed++;
        step();
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (40) step();
        total++; if (busy !== 1'b0 || done !== 1'b0 || hi_q !== '0 || lo_q !== '0)
            $display("FAIL reset_mid after: got busy %b done %b %h/%h want all zero", busy, done, hi_q, lo_q);
        else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [2:0] o;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 1000));
                3: b = -32'($urandom_range(1, 1000));
                default: ;
            endcase
            run_arith(o, a, b, $sformatf("rand%0d_op%0d", i, o));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_cpu);
        #1;
        test_reset();
        reset = 1'b1;
        step();
        test_reset();
        test_directed();
        test_mt();
        test_ignored_ops();
        test_start_while_busy();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
